// File: rtl/mips_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_pkg
// Description : Shared types and constants for the MIPS memory-bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

    localparam logic [3:0]  BE_WORD         = 4'b1111;
    localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage
`default_nettype wire

// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_arbiter
// Description : Round-robin arbiter sharing one memory bus between the
//               instruction-fetch port and the load/store port, with watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_address,
    output logic        i_ack,
    output logic [31:0] i_readdata,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [3:0]  d_byteenable,
    input  logic [31:0] d_writedata,
    output logic        d_ack,
    output logic [31:0] d_readdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        timeout,
    output logic        busy
);

    localparam int              CW      = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_WAIT);

    state_e        state_q, state_d;
    grant_e        last_q, last_d;
    logic [31:0]   address_q, address_d;
    logic          read_q, read_d;
    logic          write_q, write_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          timeout_q, timeout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    grant_e        gnt_sel;

    assign cnt_inc = cnt_q + 1'b1;

    // Contention goes to whichever port did not win last time.
    always_comb begin
        gnt_sel = GNT_D;
        if (i_req && d_req) begin
            gnt_sel = (last_q == GNT_D) ? GNT_I : GNT_D;
        end else if (i_req) begin
            gnt_sel = GNT_I;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        address_d = address_q;
        read_d    = read_q;
        write_d   = write_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d = BUS;
                    last_d  = gnt_sel;
                    cnt_d   = '0;
                    if (gnt_sel == GNT_I) begin
                        address_d = i_address & ADDR_ALIGN_MASK;
                        read_d    = 1'b1;
                        write_d   = 1'b0;
                        be_d      = BE_WORD;
                    end else begin
                        address_d = d_address & ADDR_ALIGN_MASK;
                        read_d    = ~d_write;
                        write_d   = d_write;
                        be_d      = d_byteenable;
                        wdata_d   = d_writedata;
                    end
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = RESP;
                    if (last_q == GNT_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = readdata;
                    end else begin
                        d_ack_d = 1'b1;
                        if (read_q) d_rdata_d = readdata;
                    end
                end else if ((MAX_WAIT != 0) && (cnt_inc == CNT_MAX)) begin
                    // Abort: complete the transfer with zero data and flag it.
                    read_d    = 1'b0;
                    write_d   = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                    if (last_q == GNT_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = 32'h0;
                    end else begin
                        d_ack_d = 1'b1;
                        if (read_q) d_rdata_d = 32'h0;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= GNT_D;
            address_q <= 32'h0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            be_q      <= 4'h0;
            wdata_q   <= 32'h0;
            i_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            address_q <= address_d;
            read_q    <= read_d;
            write_q   <= write_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign byteenable = be_q;
    assign writedata  = wdata_q;
    assign i_readdata = i_rdata_q;
    assign d_readdata = d_rdata_q;
    assign i_ack      = i_ack_q;
    assign d_ack      = d_ack_q;
    assign timeout    = timeout_q;
    assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_bus_arbiter
// Description : Directed self-checking bench for mips_bus_arbiter (MAX_WAIT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_address;
    logic        i_ack;
    logic [31:0] i_readdata;
    logic        d_req;
    logic        d_write;
    logic [31:0] d_address;
    logic [3:0]  d_byteenable;
    logic [31:0] d_writedata;
    logic        d_ack;
    logic [31:0] d_readdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        timeout;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int i_ack_count = 0;
    int d_ack_count = 0;

    mips_bus_arbiter #(.MAX_WAIT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_address    (i_address),
        .i_ack        (i_ack),
        .i_readdata   (i_readdata),
        .d_req        (d_req),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_byteenable (d_byteenable),
        .d_writedata  (d_writedata),
        .d_ack        (d_ack),
        .d_readdata   (d_readdata),
        .address      (address),
        .read         (read),
        .write        (write),
        .byteenable   (byteenable),
        .writedata    (writedata),
        .waitrequest  (waitrequest),
        .readdata     (readdata),
        .timeout      (timeout),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (i_ack) i_ack_count <= i_ack_count + 1;
        if (d_ack) d_ack_count <= d_ack_count + 1;
    end

    // Advance one edge, then check the invariants that must hold every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        checks++;
        if (read && write) begin
            failures++;
            $display("FAIL rw_exclusive: read=%b write=%b, required not both 1", read, write);
        end
        checks++;
        if (i_ack && d_ack) begin
            failures++;
            $display("FAIL ack_exclusive: i_ack=%b d_ack=%b, required not both 1", i_ack, d_ack);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({read, write, i_ack, d_ack, timeout, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b required 000000", {read, write, i_ack, d_ack, timeout, busy});
        end
        checks++;
        if ({address, writedata, i_readdata, d_readdata, byteenable} !== 132'h0) begin
            failures++;
            $display("FAIL reset_data: addr=%h wd=%h ird=%h drd=%h be=%h required all 0",
                     address, writedata, i_readdata, d_readdata, byteenable);
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        i_req = 1'b1; i_address = 32'd100; readdata = 32'h8C010004; waitrequest = 1'b0;
        tick();
        checks++;
        if ({read, write, busy} !== 3'b101 || address !== 32'd100 || byteenable !== 4'hF) begin
            failures++;
            $display("FAIL fetch_cycle1: rd=%b wr=%b busy=%b addr=%h be=%h required 1 0 1 00000064 f",
                     read, write, busy, address, byteenable);
        end
        tick();
        checks++;
        if (i_ack !== 1'b1 || i_readdata !== 32'h8C010004 || read !== 1'b0) begin
            failures++;
            $display("FAIL fetch_ack: i_ack=%b ird=%h rd=%b required 1 8c010004 0", i_ack, i_readdata, read);
        end
        i_req = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || i_ack !== 1'b0) begin
            failures++;
            $display("FAIL fetch_idle: busy=%b i_ack=%b required 0 0", busy, i_ack);
        end
    endtask

    task automatic test_align_load();
        d_req = 1'b1; d_write = 1'b0; d_address = 32'hBFC00007; d_byteenable = 4'b0110;
        readdata = 32'h1234_5678; waitrequest = 1'b0;
        tick();
        checks++;
        if (address !== 32'hBFC00004 || {read, write} !== 2'b10 || byteenable !== 4'b0110) begin
            failures++;
            $display("FAIL align_addr: addr=%h rd=%b wr=%b be=%b required bfc00004 1 0 0110",
                     address, read, write, byteenable);
        end
        tick();
        checks++;
        if (d_ack !== 1'b1 || d_readdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL align_ack: d_ack=%b drd=%h required 1 12345678", d_ack, d_readdata);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_store_wait();
        d_req = 1'b1; d_write = 1'b1; d_address = 32'd8; d_byteenable = 4'b0011;
        d_writedata = 32'h5C3A18FC; waitrequest = 1'b1; readdata = 32'hDEAD_BEEF;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({write, read} !== 2'b10 || address !== 32'd8 || writedata !== 32'h5C3A18FC ||
                byteenable !== 4'b0011 || d_ack !== 1'b0) begin
                failures++;
                $display("FAIL store_hold[%0d]: wr=%b rd=%b addr=%h wd=%h be=%b ack=%b required 1 0 8 5c3a18fc 0011 0",
                         k, write, read, address, writedata, byteenable, d_ack);
            end
            if (k == 3) waitrequest = 1'b0;
            tick();
        end
        checks++;
        if (d_ack !== 1'b1 || write !== 1'b0 || d_readdata !== 32'h1234_5678 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL store_ack: d_ack=%b wr=%b drd=%h to=%b required 1 0 12345678 0",
                     d_ack, write, d_readdata, timeout);
        end
        d_req = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || d_ack !== 1'b0) begin
            failures++;
            $display("FAIL store_idle: busy=%b d_ack=%b required 0 0", busy, d_ack);
        end
    endtask

    task automatic test_contention();
        int i0, d0;
        reset = 1'b1;
        i_req = 1'b1; i_address = 32'h0000_0200;
        d_req = 1'b1; d_write = 1'b0; d_address = 32'h0000_0300; d_byteenable = 4'b1111;
        waitrequest = 1'b0; readdata = 32'hAAAA_0001;
        tick();
        i0 = i_ack_count; d0 = d_ack_count;
        reset = 1'b0;
        tick();
        checks++;
        if (address !== 32'h0000_0200 || read !== 1'b1) begin
            failures++;
            $display("FAIL cont_first_grant: addr=%h rd=%b required 00000200 1", address, read);
        end
        tick();
        checks++;
        if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_readdata !== 32'hAAAA_0001) begin
            failures++;
            $display("FAIL cont_i_ack: i_ack=%b d_ack=%b ird=%h required 1 0 aaaa0001", i_ack, d_ack, i_readdata);
        end
        i_req = 1'b0; readdata = 32'hBBBB_0002;
        tick();
        tick();
        checks++;
        if (address !== 32'h0000_0300 || read !== 1'b1) begin
            failures++;
            $display("FAIL cont_second_grant: addr=%h rd=%b required 00000300 1", address, read);
        end
        tick();
        checks++;
        if (d_ack !== 1'b1 || d_readdata !== 32'hBBBB_0002) begin
            failures++;
            $display("FAIL cont_d_ack: d_ack=%b drd=%h required 1 bbbb0002", d_ack, d_readdata);
        end
        d_req = 1'b0;
        tick();
        tick();
        checks++;
        if (i_ack_count - i0 !== 1 || d_ack_count - d0 !== 1) begin
            failures++;
            $display("FAIL cont_ack_counts: i=%0d d=%0d required 1 1", i_ack_count - i0, d_ack_count - d0);
        end
    endtask

    task automatic test_watchdog();
        d_req = 1'b1; d_write = 1'b0; d_address = 32'h0000_0040; d_byteenable = 4'b1111;
        waitrequest = 1'b1; readdata = 32'hCAFE_F00D;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (read !== 1'b1 || d_ack !== 1'b0 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL wd_wait[%0d]: rd=%b ack=%b to=%b required 1 0 0", k, read, d_ack, timeout);
            end
            tick();
        end
        checks++;
        if (read !== 1'b0 || d_ack !== 1'b1 || d_readdata !== 32'h0 || timeout !== 1'b1) begin
            failures++;
            $display("FAIL wd_abort: rd=%b ack=%b drd=%h to=%b required 0 1 00000000 1",
                     read, d_ack, d_readdata, timeout);
        end
        d_req = 1'b0; waitrequest = 1'b0;
        tick();
        i_req = 1'b1; i_address = 32'h10; readdata = 32'h1;
        tick();
        tick();
        i_req = 1'b0;
        tick();
        checks++;
        if (timeout !== 1'b1 || i_readdata !== 32'h1) begin
            failures++;
            $display("FAIL wd_sticky: to=%b ird=%h required 1 00000001", timeout, i_readdata);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int i0;
        i0 = i_ack_count;
        i_req = 1'b1; i_address = 32'h0000_0400; waitrequest = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (read !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0 || address !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid: rd=%b busy=%b to=%b addr=%h required 0 0 0 00000000",
                     read, busy, timeout, address);
        end
        reset = 1'b0; i_req = 1'b0; waitrequest = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (i_ack_count - i0 !== 0) begin
            failures++;
            $display("FAIL rst_no_ack: i_ack pulses=%0d required 0", i_ack_count - i0);
        end
    endtask

    initial begin
        reset = 1'b1; i_req = 1'b0; i_address = 32'h0;
        d_req = 1'b0; d_write = 1'b0; d_address = 32'h0; d_byteenable = 4'h0; d_writedata = 32'h0;
        waitrequest = 1'b0; readdata = 32'h0;
        test_reset();
        test_fetch();
        test_align_load();
        test_store_wait();
        test_contention();
        test_watchdog();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
Shares the CPU's single memory bus (address/read/write/waitrequest/byteenable/writedata/readdata) between two requesters: instruction fetch (I-port, read-only) and load/store (D-port).
- Grants one transaction at a time, using round-robin on contention.
- Holds the bus while waitrequest is high and returns read data with a one-cycle ack.
- Sits between the mips_cpu_bus core logic and the external memory bus.
- Includes a watchdog that aborts a stalled transfer.

Parameters:
MAX_WAIT, 255, number of consecutive waitrequest-high bus cycles before abort; 0 disables the watchdog.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
i_req  in  1  fetch request; level signal, held until i_ack.
i_address  in  32  fetch byte address.
i_ack  out  1  one-cycle pulse: fetch complete.
i_readdata  out  32  fetched word; valid from the i_ack cycle until the next I-transaction.
d_req  in  1  data request; level signal, held until d_ack.
d_write  in  1  1 = store, 0 = load.
d_address  in  32  data byte address.
d_byteenable  in  4  lane enables for the data access.
d_writedata  in  32  store data.
d_ack  out  1  one-cycle pulse: data access complete.
d_readdata  out  32  load word; updated only on load completion.
address  out  32  bus address; bits [1:0] are always 0.
read  out  1  bus read strobe.
write  out  1  bus write strobe.
byteenable  out  4  bus lane enables.
writedata  out  32  bus write data.
waitrequest  in  1  slave stall.
readdata  in  32  bus read data; valid in a read cycle where waitrequest = 0.
timeout  out  1  sticky watchdog error flag.
busy  out  1  high in every state except IDLE.

Behaviour:
Reset values (all outputs registered):
- State IDLE.
- read, write, i_ack, d_ack, timeout = 0.
- address, writedata, i_readdata, d_readdata = 0; byteenable = 0.
- last_grant = D, so the first contended grant goes to the I-port.

States: IDLE, BUS, RESP.

IDLE:
- Samples i_req and d_req.
- If exactly one is high, grant that port.
- If both are high, grant the port not in last_grant.
- On grant: next state BUS and last_grant updates.
- Registered bus outputs for an I grant: address = {i_address[31:2], 2'b00}, read = 1, byteenable = 4'b1111.
- Registered bus outputs for a D grant: address = {d_address[31:2], 2'b00}, read = ~d_write, write = d_write, byteenable = d_byteenable, writedata = d_writedata.
- The wait counter clears.

BUS:
- All bus outputs stay stable while waitrequest = 1, and the wait counter increments.
- On an edge with waitrequest = 0:
  - read and write drop.
  - For a read, readdata is captured into i_readdata or d_readdata.
  - The matching ack is set; next state RESP.
- Watchdog: if MAX_WAIT ≠ 0 and the counter reaches MAX_WAIT while waitrequest is still 1:
  - read and write drop.
  - The granted readdata register is loaded with 32'h0 (loads and fetches only).
  - The ack is issued and timeout is set; timeout stays 1 until reset.

RESP:
- Ack is high for exactly this one cycle; requests are not sampled.
- Ack clears and the next state is IDLE.
- The requester must drop or update req at the edge ending the ack cycle.

Latency (zero wait states):
- Request sampled at edge E0; bus strobe high in cycle 1; ack in cycle 2; next grant sampled in cycle 3.
- Each wait cycle adds one cycle.

Rules:
- read and write are never high together.
- At most one ack is high per cycle.
- A requester's inputs are ignored outside its own IDLE grant edge; they are latched at grant.
- d_readdata is unchanged on store completion.

Reset mid-transaction:
- The next edge forces IDLE, read = write = 0, and all other outputs to reset values.
- No ack is issued; the requester re-issues its request.

Decomposition:
- Package mips_bus_pkg holds:
  - state enum {IDLE, BUS, RESP};
  - grant enum {GNT_I, GNT_D};
  - constant BE_WORD = 4'b1111;
  - constant ADDR_ALIGN_MASK = 32'hFFFF_FFFC.
- Single module; no sub-module. The wait counter is inline, sized $clog2(MAX_WAIT+1), minimum 1 bit.

Test Plan:
- i_req = 1, i_address = 100, readdata = 32'h8C010004, waitrequest = 0 → read = 1 and address = 100 in cycle 1; i_ack with i_readdata = 32'h8C010004 in cycle 2; busy low in cycle 3.
- d_req = 1, d_write = 1, d_address = 8, d_byteenable = 4'b0011, d_writedata = 32'h5C3A18FC, waitrequest high 3 cycles → write held 4 cycles with stable address/writedata/byteenable; d_ack one cycle later; d_readdata unchanged.
- i_req and d_req both high at reset release → I granted first; D granted at the next IDLE; each ack fires exactly once.
- d_address = 32'hBFC00007 load → bus address = 32'hBFC00004.
- MAX_WAIT = 4, waitrequest stuck at 1 on a load → read drops after 4 wait cycles; d_ack with d_readdata = 0; timeout = 1 and stays 1 until reset.
- reset asserted in the second waitrequest cycle of a fetch → next cycle read = 0 and busy = 0; no i_ack ever issued.
